lcd_char_writer: RTL and testbench

//  HD44780-compatible 16x2 character LCD writer, 8-bit bus, write-only.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_delay_timer.sv | 28 ++
 rtl/lcd_char_writer.sv | 163 ++++++++++++++++
 tb/tb_lcd_char_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the character LCD writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    EN_LO,
    BUSY
  } lcd_state_t;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] ADDR_L1       = 8'h80;
  localparam logic [7:0] ADDR_L2       = 8'hC0;
  localparam logic [7:0] FF_CHAR       = 8'h0C;

  localparam logic [2:0] INIT_LEN = 3'd5;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = FUNC_SET_8B2L;
      3'd2:       init_cmd = DISP_ON;
      3'd3:       init_cmd = CLEAR;
      default:    init_cmd = ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done pulses on the last cycle of a loaded interval,
// so a state entered with start/load=N is occupied for exactly N cycles.
module lcd_delay_timer #(
  parameter int W = 16,
  parameter int unsigned RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      cnt_reg <= W'(RST_VAL);
    end else if (start) begin
      cnt_reg <= load;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign done = (cnt_reg == W'(1));

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 8-bit write-only driver: power-on init, per-byte write strobes,
// form-feed clear and automatic line wrap between the two display lines.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int POWERON_US    = 20_000,
  parameter int EN_CYC        = 16,
  parameter int CMD_WAIT_US   = 50,
  parameter int CLEAR_WAIT_US = 2_000,
  parameter int LINE_LEN      = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int MAX_US     = (POWERON_US > CLEAR_WAIT_US) ? POWERON_US : CLEAR_WAIT_US;
  localparam int TIMER_W    = $clog2(CYC_PER_US * MAX_US) + 1;
  localparam int COL_W      = $clog2(LINE_LEN + 1);

  localparam logic [TIMER_W-1:0] EN_CYC_T  = TIMER_W'(EN_CYC);
  localparam logic [TIMER_W-1:0] CMD_CYC   = TIMER_W'(CMD_WAIT_US * CYC_PER_US);
  localparam logic [TIMER_W-1:0] CLEAR_CYC = TIMER_W'(CLEAR_WAIT_US * CYC_PER_US);

  lcd_state_t         state_reg, state_next;
  logic [2:0]         init_idx_reg, init_idx_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic               line_reg, line_next;
  logic               pending_reg, pending_next;
  logic [7:0]         data_reg;
  logic               rs_reg, long_wait_reg, en_reg;

  logic               load_cmd, cmd_rs, cmd_long;
  logic [7:0]         cmd_data;
  logic               timer_start, timer_done;
  logic [TIMER_W-1:0] timer_load;

  lcd_delay_timer #(
    .W       (TIMER_W),
    .RST_VAL (POWERON_US * CYC_PER_US)
  ) u_timer (
    .clk   (clk),
    .rstb  (rstb),
    .start (timer_start),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    col_next      = col_reg;
    line_next     = line_reg;
    pending_next  = pending_reg;
    load_cmd      = 1'b0;
    cmd_data      = 8'h00;
    cmd_rs        = 1'b0;
    cmd_long      = 1'b0;
    timer_start   = 1'b0;
    timer_load    = '0;
    case (state_reg)
      PWR_WAIT: if (timer_done) state_next = INIT;
      INIT: begin
        load_cmd   = 1'b1;
        cmd_data   = init_cmd(init_idx_reg);
        cmd_long   = (init_cmd(init_idx_reg) == CLEAR);
        state_next = SETUP;
      end
      IDLE: if (char_valid) begin
        load_cmd   = 1'b1;
        state_next = SETUP;
        if (char_in == FF_CHAR) begin
          cmd_data  = CLEAR;
          cmd_long  = 1'b1;
          col_next  = '0;
          line_next = 1'b0;
        end else begin
          cmd_data = char_in;
          cmd_rs   = 1'b1;
          // Cursor bookkeeping happens at acceptance; the address fix-up
          // command is queued behind this character's busy wait.
          if (col_reg == COL_W'(LINE_LEN - 1)) begin
            col_next     = '0;
            line_next    = ~line_reg;
            pending_next = 1'b1;
          end else begin
            col_next = col_reg + COL_W'(1);
          end
        end
      end
      SETUP: begin
        timer_start = 1'b1;
        timer_load  = EN_CYC_T;
        state_next  = EN_HI;
      end
      EN_HI: if (timer_done) begin
        timer_start = 1'b1;
        timer_load  = EN_CYC_T;
        state_next  = EN_LO;
      end
      EN_LO: if (timer_done) begin
        timer_start = 1'b1;
        timer_load  = long_wait_reg ? CLEAR_CYC : CMD_CYC;
        state_next  = BUSY;
      end
      BUSY: if (timer_done) begin
        if (pending_reg) begin
          load_cmd     = 1'b1;
          cmd_data     = line_reg ? ADDR_L2 : ADDR_L1;
          pending_next = 1'b0;
          state_next   = SETUP;
        end else if (init_idx_reg < INIT_LEN) begin
          init_idx_next = init_idx_reg + 3'd1;
          state_next    = (init_idx_reg == INIT_LEN - 3'd1) ? IDLE : INIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_reg     <= PWR_WAIT;
      init_idx_reg  <= 3'd0;
      col_reg       <= '0;
      line_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      data_reg      <= 8'h00;
      rs_reg        <= 1'b0;
      long_wait_reg <= 1'b0;
      en_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
      col_reg      <= col_next;
      line_reg     <= line_next;
      pending_reg  <= pending_next;
      en_reg       <= (state_next == EN_HI);
      if (load_cmd) begin
        data_reg      <= cmd_data;
        rs_reg        <= cmd_rs;
        long_wait_reg <= cmd_long;
      end
    end
  end

  assign char_ready = (state_reg == IDLE);
  assign lcd_data   = data_reg;
  assign lcd_rs     = rs_reg;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_reg;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer: bus monitor checks strobe timing and
// compares every strobe against a cursor/queue model of the display.
module tb_lcd_char_writer;

  localparam int POWERON = 20_000;
  localparam int EN_CYC  = 2;
  localparam int CMD_W   = 50;
  localparam int CLR_W   = 2_000;
  localparam int LINE_LEN = 16;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  always #5 clk = ~clk;

  lcd_char_writer #(
    .CLK_HZ        (1_000_000),
    .POWERON_US    (POWERON),
    .EN_CYC        (EN_CYC),
    .CMD_WAIT_US   (CMD_W),
    .CLEAR_WAIT_US (CLR_W),
    .LINE_LEN      (LINE_LEN)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Display model: expected strobes as {rs, data}, derived from cursor rules.
  logic [8:0] exp_q[$];
  int m_col, m_line;

  function automatic void model_reset();
    m_col  = 0;
    m_line = 0;
    exp_q  = {9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (b == 8'h0C) begin
      exp_q.push_back(9'h001);
      m_col  = 0;
      m_line = 0;
    end else begin
      exp_q.push_back({1'b1, b});
      m_col++;
      if (m_col == LINE_LEN) begin
        m_col  = 0;
        m_line = 1 - m_line;
        exp_q.push_back((m_line == 1) ? 9'h0C0 : 9'h080);
      end
    end
  endfunction

  // Bus monitor, sampled on the falling edge.
  logic       en_q = 1'b0, ready_q = 1'b0, first_strobe = 1'b1, have_fall = 1'b0;
  logic [8:0] bus, bus_q = '0, strobe_bus = '0, e;
  int         hi_cnt = 0, hold_left = 0, fall_cyc = 0, need_wait = 0;

  always @(negedge clk) begin
    if (rstb) begin
      cyc = 0; en_q = 1'b0; ready_q = 1'b0; first_strobe = 1'b1; have_fall = 1'b0;
      hi_cnt = 0; hold_left = 0; bus_q = '0;
    end else begin
      cyc++;
      bus = {lcd_rs, lcd_data};
      if (lcd_en && !en_q) begin
        if (first_strobe) check("poweron_wait", 32'(cyc >= POWERON), 32'd1);
        else check("busy_wait", 32'((cyc - fall_cyc) >= need_wait), 32'd1);
        first_strobe = 1'b0;
        check("setup_before_en", 32'(bus), 32'(bus_q));
        check("rw_low", 32'(lcd_rw), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(bus), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          check("strobe", 32'(bus), 32'(e));
        end
        strobe_bus = bus;
        hi_cnt = 1;
      end else if (lcd_en) begin
        hi_cnt++;
        check("data_during_en", 32'(bus), 32'(strobe_bus));
      end else if (en_q) begin
        check("en_width", 32'(hi_cnt), 32'(EN_CYC));
        fall_cyc  = cyc;
        have_fall = 1'b1;
        hold_left = EN_CYC;
        need_wait = (strobe_bus == 9'h001) ? CLR_W : CMD_W;
      end
      if (!lcd_en && hold_left > 0) begin
        check("hold_after_en", 32'(bus), 32'(strobe_bus));
        hold_left--;
      end
      if (char_ready && !ready_q && have_fall) begin
        check("ready_early", 32'((cyc - fall_cyc) >= need_wait), 32'd1);
        check("ready_late", 32'((cyc - fall_cyc) <= need_wait + EN_CYC + 8), 32'd1);
      end
      en_q    = lcd_en;
      ready_q = char_ready;
      bus_q   = bus;
    end
  end

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!char_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(char_ready), 32'd1);
  endtask

  // Called just after a falling edge; returns on the falling edge of the first EN_HI cycle.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    logic [9:0] setup_exp;
    char_in    = b;
    char_valid = 1'b1;
    wait_ready(3000);
    if (char_ready) begin
      model_push(b);
      setup_exp = (b == 8'h0C) ? {1'b0, 8'h01, 1'b0} : {1'b1, b, 1'b0};
      @(negedge clk);
      check("ready_drop", 32'(char_ready), 32'd0);
      check("setup_bus", 32'({lcd_rs, lcd_data, lcd_en}), 32'(setup_exp));
      @(negedge clk);
      check("en_latency", 32'(lcd_en), 32'd1);
    end
    if (!hold) char_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_char();
    return 8'($urandom_range(32'h20, 32'h7E));
  endfunction

  task automatic drain();
    wait_ready(3000);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rstb       = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_outputs", 32'({lcd_rs, lcd_data, lcd_en, lcd_rw}), 32'd0);
    #2 rstb = 1'b0;
    model_reset();
    @(negedge clk);
    wait_ready(25_000);
    check("init_drained", 32'(exp_q.size()), 32'd0);

    send_byte(8'h57, 1'b0);
    drain();

    // Clear, then a continuous stream across both wraps.
    send_byte(8'h0C, 1'b0);
    for (int i = 0; i < 32; i++) send_byte(rand_char(), 1'b1);
    char_valid = 1'b0;
    drain();

    // Form feed mid-line, then enough text to wrap from column 0.
    for (int i = 0; i < 5; i++) send_byte(rand_char(), 1'b0);
    send_byte(8'h0C, 1'b0);
    for (int i = 0; i < 17; i++) send_byte(rand_char(), 1'b0);
    drain();

    // Random mix with occasional form feeds and bytes offered while busy.
    for (int i = 0; i < 30; i++) begin
      send_byte(($urandom_range(0, 15) == 0) ? 8'h0C : rand_char(), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        check("busy_not_ready", 32'(char_ready), 32'd0);
        char_in    = rand_char();
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
      end
    end
    drain();

    // Reset asserted while EN is high.
    send_byte(8'h41, 1'b0);
    #2 rstb = 1'b1;
    #1;
    check("rst_en_immediate", 32'(lcd_en), 32'd0);
    check("rst_ready_low", 32'(char_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    model_reset();
    @(negedge clk);
    wait_ready(25_000);
    check("reinit_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(rand_char(), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
